// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the RV32I load/store unit
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_MISALIGNED = 2'b01,
    FAULT_ILLEGAL    = 2'b10
  } fault_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RWAIT,
    S_RESP
  } state_e;

  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_W:    res = word;
      F3_BU:   res = {24'h0, sh[7:0]};
      F3_HU:   res = {16'h0, sh[15:0]};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-writable word array with a READ_LATENCY-deep read pipeline
module dmem_bank #(
  parameter int WIDTH        = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [WIDTH/8-1:0]             be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem  [DEPTH_WORDS];
  logic [WIDTH-1:0] pipe [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Stage 0 is loaded on the accept edge; later stages just age the word.
  always_ff @(posedge clk) begin
    if (re) pipe[0] <= mem[raddr];
    for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[READ_LATENCY-1];

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store front-end with fault reporting over a data bank
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [1:0]       resp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_e           state, next_state;
  logic [1:0]       cnt;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic             accept, illegal, misaligned, mem_we, mem_re;
  fault_e           fault;
  logic [WIDTH-1:0] wdata_rep, rd_word;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^req_addr[WIDTH-1:AW+2];

  always_comb begin
    illegal    = req_write ? (req_funct3 > F3_W)
                           : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    fault      = illegal ? FAULT_ILLEGAL : (misaligned ? FAULT_MISALIGNED : FAULT_NONE);
    case (req_funct3[1:0])
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;
  // Reset must win over a coinciding accept so no store lands.
  assign mem_we     = accept && req_write && fault == FAULT_NONE && !rst;
  assign mem_re     = accept && !req_write && fault == FAULT_NONE;

  dmem_bank #(
    .WIDTH(WIDTH), .DEPTH_WORDS(DEPTH_WORDS), .READ_LATENCY(READ_LATENCY)
  ) u_bank (
    .clk   (clk),
    .we    (mem_we),
    .be    (byte_enable(req_funct3, req_addr[1:0])),
    .waddr (req_addr[2 +: AW]),
    .wdata (wdata_rep),
    .re    (mem_re),
    .raddr (req_addr[2 +: AW]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = (req_write || fault != FAULT_NONE) ? S_RESP : S_RWAIT;
      S_RWAIT: if (cnt == 2'd0) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 2'd0;
      f3_q       <= 3'd0;
      lo_q       <= 2'd0;
      resp_rdata <= '0;
      resp_fault <= FAULT_NONE;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          f3_q <= req_funct3;
          lo_q <= req_addr[1:0];
          cnt  <= CNT_INIT;
          if (req_write || fault != FAULT_NONE) begin
            resp_rdata <= '0;
            resp_fault <= fault;
          end
        end
        S_RWAIT: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else begin
            resp_rdata <= load_extend(rd_word, f3_q, lo_q);
            resp_fault <= FAULT_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        a_ready, a_rvalid, b_ready, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  a_fault, b_fault;
  logic        sel_b = 1'b0;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_fault;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_lsu u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_fault(a_fault)
  );

  dmem_lsu #(.DEPTH_WORDS(16), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_fault(b_fault)
  );

  assign m_ready  = sel_b ? b_ready  : a_ready;
  assign m_rvalid = sel_b ? b_rvalid : a_rvalid;
  assign m_rdata  = sel_b ? b_rdata  : a_rdata;
  assign m_fault  = sel_b ? b_fault  : a_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit use_b, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic [1:0] exp_f,
                        input int exp_lat, input string tag);
    int lat;
    sel_b      = use_b;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (use_b) b_valid = 1'b1;
    else       a_valid = 1'b1;
    check({tag, "_ready"}, 32'(m_ready), 32'd1);
    @(posedge clk);
    #1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (m_rvalid) break;
      check({tag, "_busy"}, 32'(m_ready), 32'd0);
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, m_rdata, exp_d);
    check({tag, "_fault"}, 32'(m_fault), 32'(exp_f));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(m_rvalid), 32'd0);
    check({tag, "_idle"}, 32'(m_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready_a",  32'(a_ready),  32'd1);
    check("rst_rvalid_a", 32'(a_rvalid), 32'd0);
    check("rst_rdata_a",  a_rdata,       32'd0);
    check("rst_fault_a",  32'(a_fault),  32'd0);
    check("rst_ready_b",  32'(b_ready),  32'd1);
    check("rst_rvalid_b", 32'(b_rvalid), 32'd0);
    rst = 1'b0;

    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        2'b00, 1, "sw_10");
    do_req(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 2'b00, 2, "lw_10");
    do_req(0, 1, 3'b000, 32'h13, 32'h00000080, 32'h0,        2'b00, 1, "sb_13");
    do_req(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 2'b00, 2, "lb_13");
    do_req(0, 0, 3'b100, 32'h13, 32'h0,        32'h00000080, 2'b00, 2, "lbu_13");
    do_req(0, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 2'b00, 2, "lw_merged");
    do_req(0, 1, 3'b010, 32'h10, 32'h80EF0000, 32'h0,        2'b00, 1, "sw_80ef");
    do_req(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFF80EF, 2'b00, 2, "lh_12");
    do_req(0, 0, 3'b101, 32'h12, 32'h0,        32'h000080EF, 2'b00, 2, "lhu_12");

    do_req(0, 0, 3'b010, 32'h02, 32'h0,        32'h0,        2'b01, 1, "lw_mis");
    do_req(0, 1, 3'b010, 32'h04, 32'h11223344, 32'h0,        2'b00, 1, "sw_04");
    do_req(0, 1, 3'b001, 32'h05, 32'h0000BEEF, 32'h0,        2'b01, 1, "sh_mis");
    do_req(0, 0, 3'b010, 32'h04, 32'h0,        32'h11223344, 2'b00, 2, "lw_04_kept");
    do_req(0, 1, 3'b001, 32'h06, 32'h0000BEEF, 32'h0,        2'b00, 1, "sh_06");
    do_req(0, 0, 3'b010, 32'h04, 32'h0,        32'hBEEF3344, 2'b00, 2, "lw_04_sh");
    do_req(0, 0, 3'b001, 32'h06, 32'h0,        32'hFFFFBEEF, 2'b00, 2, "lh_06");

    do_req(0, 1, 3'b010, 32'h00, 32'hA5A5A5A5, 32'h0,        2'b00, 1, "sw_00");
    do_req(0, 0, 3'b011, 32'h00, 32'h0,        32'h0,        2'b10, 1, "ld_ill");
    do_req(0, 1, 3'b100, 32'h01, 32'h000000FF, 32'h0,        2'b10, 1, "st_ill");
    do_req(0, 0, 3'b010, 32'h00, 32'h0,        32'hA5A5A5A5, 2'b00, 2, "lw_00_kept");

    do_req(1, 1, 3'b010, 32'h40, 32'h12345678, 32'h0,        2'b00, 1, "b_sw_40");
    do_req(1, 0, 3'b010, 32'h00, 32'h0,        32'h12345678, 2'b00, 4, "b_lw_wrap");

    do_req(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0,        2'b00, 1, "sw_20");
    sel_b = 1'b0; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    check("rwait_busy", 32'(a_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_mid_ready",  32'(a_ready),  32'd1);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_quiet", 32'(a_rvalid), 32'd0);
    end

    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0BADBEEF;
    rst = 1'b1; a_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; a_valid = 1'b0;
    check("rst_acc_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_acc_ready",  32'(a_ready),  32'd1);
    @(negedge clk);
    do_req(0, 0, 3'b010, 32'h20, 32'h0,        32'hCAFEF00D, 2'b00, 2, "lw_20_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised load/store front-end plus data memory. It is the successor to the word-addressed, byte-enable data RAM.
- Accepts byte-addressed RV32I load/store requests over a valid/ready handshake.
- Generates byte enables and lane-shifts store data.
- Performs a synchronous read with configurable latency.
- Sign- or zero-extends load data.
- Reports misaligned and illegal-funct3 accesses instead of touching memory.
- Sits between the core's MEM stage and the storage array; one request is outstanding at a time.

Parameters:
WIDTH, 32, data/address width in bits; only 32 is supported (RV32I).
DEPTH_WORDS, 1024, number of words in the array; must be a power of two.
READ_LATENCY, 1, number of cycles from request accept to read data being captured; legal range 1..3.

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, right-aligned (LSB lanes)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  WIDTH  extended load data; 0 for stores and faults
resp_fault  output  2  00 ok, 01 misaligned, 10 illegal funct3

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=00; latency counter=0. Memory contents are not cleared.
- Accept condition: req_valid && req_ready. req_ready=1 only in IDLE.
- Word index: req_addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4 bytes.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal (including 011/11x for loads and >=011 for stores).
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Illegal funct3 takes priority over misaligned.
- Byte enables:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << addr[1:0].
  - SW: 1111.
  - Store data is replicated into the lanes: byte duplicated x4, half duplicated x2.
- FSM states:
  - IDLE:
    - Accepted fault: no memory access -> RESP.
    - Accepted store: write with byte enables on the accept edge -> RESP.
    - Accepted load: read address registered, counter = READ_LATENCY-1 -> RWAIT.
  - RWAIT: counter decrements each cycle. When it reaches 0, the read word is captured; the lane is selected by addr[1:0] and extended per funct3 -> RESP.
  - RESP: resp_valid=1 for exactly one cycle with registered rdata/fault -> IDLE.
- Latency from the accept edge to resp_valid high:
  - Store/fault: 1 cycle.
  - Load: READ_LATENCY+1 cycles.
- Outputs in non-RESP cycles: resp_rdata/resp_fault hold their last value; resp_valid=0.
- No back-pressure on the response: the consumer must take it.
- Request fields are sampled only at accept and registered internally; changes afterwards are ignored.
- Reset mid-operation: the pending response is discarded (no resp_valid). A store already committed on an earlier edge stays in memory. If rst and accept coincide, reset wins and no write occurs.
- Load after store to the same address: sees the new data, because the load cannot be accepted before the store's RESP cycle has passed.

Decomposition:
- Package dmem_pkg holds:
  - funct3 enum/localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Fault enum: FAULT_NONE, FAULT_MISALIGNED, FAULT_ILLEGAL.
  - FSM state typedef.
  - Functions: byte_enable(funct3, addr_lo), load_extend(word, funct3, addr_lo).
- One sub-module, dmem_bank: a DEPTH_WORDS x WIDTH array with per-byte write enable and a registered read pipeline of depth READ_LATENCY.

Test Plan:
- Store/load round trip: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, fault=00, resp_valid 2 cycles after load accept (READ_LATENCY=1).
- Byte and halfword loads: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 with prior word 0x80EF0000 -> 0xFFFF80EF.
- Misaligned accesses: LW @0x02 -> fault=01, rdata=0, resp 1 cycle after accept. SH @0x05 -> fault=01, and a following LW @0x04 returns the unchanged word.
- Illegal funct3: load funct3=011 @0x00 -> fault=10. Store funct3=100 @0x01 -> fault=10 (illegal beats misaligned), no write.
- Wrap and latency: with DEPTH_WORDS=16 and READ_LATENCY=3, SW 0x12345678 @0x40 then LW @0x00 -> 0x12345678. resp_valid comes 4 cycles after accept, and req_ready stays 0 throughout.
- Reset mid-operation: assert rst in RWAIT -> no resp_valid, req_ready=1 the next cycle, and earlier stored data is intact on a re-read.
